// File: rtl/game_session_ctrl.sv
// +--------------------------------------------------------------------------+
// | Module   : game_session_ctrl                                             |
// | Desc     : In-game session responder: countdown, scoring, exit request   |
// |            with req/ack handshake back to the menu FSM.                  |
// |            Optional high-score tracking: GAME_SESSION_HIGH_SCORE_EN.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module game_session_ctrl #(
  parameter int unsigned TICK_DIV    = 100000000,
  parameter int unsigned GAME_TIME   = 60,
  parameter int unsigned HOLD_CYCLES = 200000000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [2:0] menu_state,
  input  logic       button_up,
  input  logic       button_down,
  input  logic       button_left,
  output logic       game_exit,
  output logic       game_active,
  output logic [1:0] game_id,
  output logic [1:0] exit_cause,
  output logic [7:0] score,
  output logic [7:0] time_left,
  output logic [7:0] high_score
);

  localparam logic [1:0]  S_IDLE      = 2'd0;
  localparam logic [1:0]  S_RUN       = 2'd1;
  localparam logic [1:0]  S_EXIT_REQ  = 2'd2;

  localparam logic [26:0] c_TICK_LAST = 27'(TICK_DIV - 1);
  localparam logic [27:0] c_HOLD_LAST = 28'(HOLD_CYCLES - 1);
  localparam logic [7:0]  c_GAME_TIME = 8'(GAME_TIME);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic              r_up_prev;
  logic              r_down_prev;
  logic [7:0]        r_score;
  logic [7:0]        r_time_left;
  logic [26:0]       r_tick_cnt;
  logic [27:0]       r_hold_cnt;
  logic [1:0]        r_game_id;
  logic [1:0]        r_exit_cause;

  logic              w_in_game;
  logic              w_up_press;
  logic              w_down_press;
  logic              w_tick_wrap;
  logic              w_timeout;
  logic              w_user_exit;
  logic signed [9:0] w_score_sum;
  logic [7:0]        w_score_nxt;

  assign w_in_game    = (menu_state == 3'd4) || (menu_state == 3'd5);
  assign w_up_press   = button_up & ~r_up_prev;
  assign w_down_press = button_down & ~r_down_prev;
  assign w_tick_wrap  = (r_tick_cnt == c_TICK_LAST);
  assign w_timeout    = w_tick_wrap && (r_time_left == 8'd1);
  assign w_user_exit  = button_left && (r_hold_cnt == c_HOLD_LAST);

  // Game 2 with both presses nets +2-1 = +1; clamp to the 8-bit range.
  always_comb begin
    w_score_sum = $signed({2'b00, r_score});
    if (w_up_press) begin
      w_score_sum = w_score_sum + ((r_game_id == 2'd2) ? 10'sd2 : 10'sd1);
    end
    if (w_down_press && (r_game_id == 2'd2)) begin
      w_score_sum = w_score_sum - 10'sd1;
    end
    if (w_score_sum > 10'sd255) begin
      w_score_nxt = 8'd255;
    end else if (w_score_sum < 10'sd0) begin
      w_score_nxt = 8'd0;
    end else begin
      w_score_nxt = w_score_sum[7:0];
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Leaving {4,5} doubles as the abort in RUN and the ack in EXIT_REQ.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_in_game) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!w_in_game) begin
          w_state_nxt = S_IDLE;
        end else if (w_timeout || w_user_exit) begin
          w_state_nxt = S_EXIT_REQ;
        end
      end
      S_EXIT_REQ: begin
        if (!w_in_game) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    game_active = 1'b0;
    game_exit   = 1'b0;
    case (r_state)
      S_RUN:      game_active = 1'b1;
      S_EXIT_REQ: game_exit   = 1'b1;
      default:    ;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_up_prev    <= 1'b0;
      r_down_prev  <= 1'b0;
      r_score      <= 8'd0;
      r_time_left  <= 8'd0;
      r_tick_cnt   <= 27'd0;
      r_hold_cnt   <= 28'd0;
      r_game_id    <= 2'd0;
      r_exit_cause <= 2'd0;
    end else begin
      r_up_prev   <= button_up;
      r_down_prev <= button_down;
      case (r_state)
        S_IDLE: begin
          if (w_in_game) begin
            r_game_id    <= (menu_state == 3'd5) ? 2'd2 : 2'd1;
            r_score      <= 8'd0;
            r_time_left  <= c_GAME_TIME;
            r_tick_cnt   <= 27'd0;
            r_hold_cnt   <= 28'd0;
            r_exit_cause <= 2'd0;
          end
        end
        S_RUN: begin
          if (!w_in_game) begin
            r_game_id    <= 2'd0;
            r_exit_cause <= 2'd0;
          end else begin
            r_score    <= w_score_nxt;
            r_tick_cnt <= w_tick_wrap ? 27'd0 : r_tick_cnt + 27'd1;
            r_hold_cnt <= button_left ? r_hold_cnt + 28'd1 : 28'd0;
            if (w_tick_wrap) begin
              r_time_left <= r_time_left - 8'd1;
            end
            // Timeout takes precedence when both exits land together.
            if (w_timeout) begin
              r_exit_cause <= 2'd1;
            end else if (w_user_exit) begin
              r_exit_cause <= 2'd2;
            end
          end
        end
        S_EXIT_REQ: begin
          if (!w_in_game) r_game_id <= 2'd0;
        end
        default: ;
      endcase
    end
  end

  assign game_id    = r_game_id;
  assign exit_cause = r_exit_cause;
  assign score      = r_score;
  assign time_left  = r_time_left;

`ifdef GAME_SESSION_HIGH_SCORE_EN
  logic [7:0] r_high_score;

  // Compared against the post-event score so a press in the exit cycle counts.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_high_score <= 8'd0;
    end else if ((r_state == S_RUN) && (w_state_nxt == S_EXIT_REQ) &&
                 (w_score_nxt > r_high_score)) begin
      r_high_score <= w_score_nxt;
    end
  end

  assign high_score = r_high_score;
`else
  assign high_score = 8'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_game_session_ctrl.sv
// +--------------------------------------------------------------------------+
// | Module   : tb_game_session_ctrl                                          |
// | Desc     : Scoreboard bench for game_session_ctrl with a session model.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_game_session_ctrl;

  localparam int TD      = 10;
  localparam int GT      = 200;
  localparam int HC      = 20;
  localparam int RUN_LEN = TD * GT;
`ifdef GAME_SESSION_HIGH_SCORE_EN
  localparam bit HS_EN = 1'b1;
`else
  localparam bit HS_EN = 1'b0;
`endif

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic [2:0] menu_state;
  logic       button_up;
  logic       button_down;
  logic       button_left;
  logic       game_exit;
  logic       game_active;
  logic [1:0] game_id;
  logic [1:0] exit_cause;
  logic [7:0] score;
  logic [7:0] time_left;
  logic [7:0] high_score;

  always #5 sys_clk = ~sys_clk;

  game_session_ctrl #(
    .TICK_DIV   (TD),
    .GAME_TIME  (GT),
    .HOLD_CYCLES(HC)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .menu_state (menu_state),
    .button_up  (button_up),
    .button_down(button_down),
    .button_left(button_left),
    .game_exit  (game_exit),
    .game_active(game_active),
    .game_id    (game_id),
    .exit_cause (exit_cause),
    .score      (score),
    .time_left  (time_left),
    .high_score (high_score)
  );

  typedef struct {
    int ge; int ga; int gid; int cause; int sc; int tl; int hs;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Session-level reference: phase 0 idle, 1 playing, 2 waiting for ack.
  int m_phase = 0, m_game = 0, m_score = 0, m_time = 0, m_elapsed = 0;
  int m_hold = 0, m_cause = 0, m_high = 0, m_pu = 0, m_pd = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int  delta;
    bit  up_ev, dn_ev, in_game;
    if (!sys_rst_n) begin
      m_phase = 0; m_game = 0; m_score = 0; m_time = 0; m_elapsed = 0;
      m_hold = 0; m_cause = 0; m_high = 0; m_pu = 0; m_pd = 0;
    end else begin
      up_ev   = (button_up == 1'b1) && (m_pu == 0);
      dn_ev   = (button_down == 1'b1) && (m_pd == 0);
      in_game = (menu_state == 3'd4) || (menu_state == 3'd5);
      if (m_phase == 0) begin
        if (in_game) begin
          m_phase = 1; m_game = (menu_state == 3'd5) ? 2 : 1;
          m_score = 0; m_time = GT; m_elapsed = 0; m_hold = 0; m_cause = 0;
        end
      end else if (m_phase == 1) begin
        if (!in_game) begin
          m_phase = 0; m_game = 0; m_cause = 0;
        end else begin
          if (m_game == 1) delta = up_ev ? 1 : 0;
          else             delta = (up_ev ? 2 : 0) - (dn_ev ? 1 : 0);
          m_score = m_score + delta;
          if (m_score > 255) m_score = 255;
          if (m_score < 0)   m_score = 0;
          m_elapsed++;
          m_time = GT - m_elapsed / TD;
          m_hold = button_left ? m_hold + 1 : 0;
          if (m_time == 0) begin
            m_phase = 2; m_cause = 1;
          end else if (m_hold >= HC) begin
            m_phase = 2; m_cause = 2;
          end
          if (m_phase == 2 && m_score > m_high) m_high = m_score;
        end
      end else begin
        if (!in_game) begin
          m_phase = 0; m_game = 0;
        end
      end
      m_pu = int'(button_up);
      m_pd = int'(button_down);
    end
  endtask

  // Inputs are already driven; predict the next edge, then let it happen.
  task automatic step();
    exp_t e;
    model_edge();
    e.ge    = (m_phase == 2) ? 1 : 0;
    e.ga    = (m_phase == 1) ? 1 : 0;
    e.gid   = m_game;
    e.cause = m_cause;
    e.sc    = m_score;
    e.tl    = m_time;
    e.hs    = HS_EN ? m_high : 0;
    sb_q.push_back(e);
    @(posedge sys_clk);
    #2;
  endtask

  initial begin
    forever begin
      @(posedge sys_clk);
      #1;
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        chk("mon_game_exit",   int'(game_exit),   mon_e.ge);
        chk("mon_game_active", int'(game_active), mon_e.ga);
        chk("mon_game_id",     int'(game_id),     mon_e.gid);
        chk("mon_exit_cause",  int'(exit_cause),  mon_e.cause);
        chk("mon_score",       int'(score),       mon_e.sc);
        chk("mon_time_left",   int'(time_left),   mon_e.tl);
        chk("mon_high_score",  int'(high_score),  mon_e.hs);
      end
    end
  end

  task automatic press(input logic u, input logic d);
    button_up = u; button_down = d;
    step();
    button_up = 1'b0; button_down = 1'b0;
    step();
  endtask

  task automatic start(input logic [2:0] m);
    menu_state = m;
    step();
    chk("active_after_entry", int'(game_active), 1);
  endtask

  task automatic user_exit();
    button_left = 1'b1;
    repeat (HC) step();
    chk("user_exit_req", int'(game_exit), 1);
    button_left = 1'b0;
  endtask

  task automatic ack();
    menu_state = 3'd0;
    step();
    chk("exit_drop_on_ack", int'(game_exit), 0);
  endtask

  initial begin
    int g;
    int v;
    sys_rst_n = 1'b0; menu_state = 3'd0;
    button_up = 1'b0; button_down = 1'b0; button_left = 1'b0;
    repeat (3) step();
    sys_rst_n = 1'b1;
    chk("rst_game_exit", int'(game_exit), 0);
    chk("rst_score", int'(score), 0);
    chk("rst_game_id", int'(game_id), 0);

    // Timeout session
    start(3'd4);
    chk("entry_time_left", int'(time_left), GT);
    repeat (TD - 1) step();
    chk("time_before_tick", int'(time_left), GT);
    step();
    chk("time_after_tick", int'(time_left), GT - 1);
    g = TD;
    while (!game_exit && g < RUN_LEN + 10) begin
      step();
      g++;
    end
    chk("timeout_latency", g, RUN_LEN);
    chk("timeout_cause", int'(exit_cause), 1);
    chk("timeout_time_zero", int'(time_left), 0);
    repeat (5) step();
    chk("exit_held", int'(game_exit), 1);
    ack();
    chk("cause_kept_idle", int'(exit_cause), 1);

    // Game 2 scoring with floor
    start(3'd5);
    chk("game2_id", int'(game_id), 2);
    repeat (3) press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    chk("game2_score5", int'(score), 5);
    repeat (10) press(1'b0, 1'b1);
    chk("game2_floor", int'(score), 0);
    press(1'b1, 1'b1);
    chk("game2_both_net1", int'(score), 1);
    menu_state = 3'd4;
    step();
    chk("id_fixed_midrun", int'(game_id), 2);
    menu_state = 3'd0;
    step();

    // High-score sessions then an abort
    start(3'd4);
    repeat (4) press(1'b1, 1'b0);
    user_exit();
    chk("hs_sess1_score", int'(score), 4);
    ack();
    start(3'd4);
    repeat (2) press(1'b1, 1'b0);
    user_exit();
    ack();
    chk("hs_after_two", int'(high_score), HS_EN ? 4 : 0);
    start(3'd4);
    repeat (6) press(1'b1, 1'b0);
    menu_state = 3'd0;
    step();
    chk("abort_no_exit", int'(game_exit), 0);
    chk("abort_inactive", int'(game_active), 0);
    chk("abort_id", int'(game_id), 0);
    chk("abort_score_held", int'(score), 6);
    chk("abort_hs_same", int'(high_score), HS_EN ? 4 : 0);

    // Game 1 saturation and user-exit hold
    start(3'd4);
    button_up = 1'b1;
    repeat (50) step();
    button_up = 1'b0;
    step();
    chk("held_up_once", int'(score), 1);
    repeat (300) press(1'b1, 1'b0);
    chk("game1_saturate", int'(score), 255);
    button_left = 1'b1;
    repeat (HC - 1) step();
    chk("hold19_no_exit", int'(game_exit), 0);
    button_left = 1'b0;
    step();
    button_left = 1'b1;
    repeat (HC - 1) step();
    chk("hold_short_no_exit", int'(game_exit), 0);
    step();
    chk("hold20_exit", int'(game_exit), 1);
    chk("hold20_cause", int'(exit_cause), 2);
    button_left = 1'b0;
    ack();

    // Hold completes on the very cycle the timer expires
    start(3'd4);
    g = 0;
    while (!game_exit && g < RUN_LEN + 10) begin
      button_left = (m_elapsed >= RUN_LEN - HC);
      step();
      g++;
    end
    chk("simul_latency", g, RUN_LEN);
    chk("simul_cause", int'(exit_cause), 1);
    button_left = 1'b0;
    ack();

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        v = int'($urandom_range(0, 9));
        menu_state = (v < 7) ? 3'(4 + (v % 2)) : 3'($urandom_range(0, 7));
      end
      button_up   = 1'($urandom_range(0, 1));
      button_down = 1'($urandom_range(0, 1));
      button_left = ($urandom_range(0, 9) != 0);
      sys_rst_n   = ($urandom_range(0, 999) != 0);
      step();
    end
    sys_rst_n = 1'b1; menu_state = 3'd0;
    button_up = 1'b0; button_down = 1'b0; button_left = 1'b0;
    repeat (2) step();

    // Reset while waiting for the ack
    start(3'd5);
    press(1'b1, 1'b0);
    user_exit();
    sys_rst_n = 1'b0;
    step();
    chk("rst_exit_game_exit", int'(game_exit), 0);
    chk("rst_exit_active", int'(game_active), 0);
    chk("rst_exit_id", int'(game_id), 0);
    chk("rst_exit_cause", int'(exit_cause), 0);
    chk("rst_exit_score", int'(score), 0);
    chk("rst_exit_time", int'(time_left), 0);
    chk("rst_exit_hs", int'(high_score), 0);
    sys_rst_n = 1'b1; menu_state = 3'd0;
    step();
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: run still active at %0t, limit 5000000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
